// File: rtl/fp32_mul_arbiter.sv
// Round-robin arbiter that time-shares one combinational fp32 multiplier among NUM_REQ requesters.
// One multiply in flight; operands and result registered; product class flags decoded on capture.
//
// state | meaning
// IDLE  | no multiply in flight, pick next requester round-robin
// BUSY  | operands registered, waiting MUL_LAT cycles for the product
// RESP  | result held on resp_* until the consumer takes it
module fp32_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 1,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic [ID_W-1:0]       resp_id,
    output logic                  resp_nan,
    output logic                  resp_inf,
    output logic                  resp_zero,
    output logic                  busy
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   grant;
    logic              found;
    logic [ID_W-1:0]   id;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_done;
    logic [31:0]       op_a;
    logic [31:0]       op_b;

    logic              sa, sb, sp;
    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [23:0]       sig_a, sig_b, nsig_a, nsig_b;
    logic [4:0]        lz_a, lz_b;
    logic signed [10:0] exp_a, exp_b, exp_p, exp_r;
    logic [47:0]       prod, prod_n, prod_s, lost_mask;
    logic [5:0]        shamt;
    logic              guard, sticky, round_up;
    logic [24:0]       rsum;
    logic [31:0]       product;
    logic              prod_nan, prod_inf, prod_zero;

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) n = 5'(23 - i);
        end
        return n;
    endfunction

    // Multiplier: subnormal inputs are pre-normalised, result rounded to nearest even.
    always_comb begin
        sa = op_a[31];
        ea = op_a[30:23];
        fa = op_a[22:0];
        sb = op_b[31];
        eb = op_b[30:23];
        fb = op_b[22:0];
        sp = sa ^ sb;

        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        a_zero = (ea == 8'd0) && (fa == 23'd0);
        b_zero = (eb == 8'd0) && (fb == 23'd0);

        sig_a  = {ea != 8'd0, fa};
        sig_b  = {eb != 8'd0, fb};
        lz_a   = lzc24(sig_a);
        lz_b   = lzc24(sig_b);
        nsig_a = sig_a << lz_a;
        nsig_b = sig_b << lz_b;
        exp_a  = $signed({3'b000, ea | {7'd0, ea == 8'd0}}) - $signed({6'd0, lz_a});
        exp_b  = $signed({3'b000, eb | {7'd0, eb == 8'd0}}) - $signed({6'd0, lz_b});

        prod   = {24'd0, nsig_a} * {24'd0, nsig_b};
        prod_n = prod[47] ? prod : {prod[46:0], 1'b0};
        exp_p  = exp_a + exp_b - 11'sd127 + $signed({10'd0, prod[47]});

        // Tiny results are shifted into subnormal position; beyond 26 everything is sticky.
        if (exp_p > 11'sd0) begin
            shamt = 6'd0;
        end else if (exp_p < -11'sd24) begin
            shamt = 6'd26;
        end else begin
            shamt = 6'(11'sd1 - exp_p);
        end
        prod_s    = prod_n >> shamt;
        lost_mask = ~({48{1'b1}} << shamt);
        guard     = prod_s[23];
        sticky    = (|prod_s[22:0]) | (|(prod_n & lost_mask));
        round_up  = guard & (sticky | prod_s[24]);
        rsum      = {1'b0, prod_s[47:24]} + {24'd0, round_up};

        if (shamt != 6'd0) begin
            exp_r = $signed({10'd0, rsum[23]});
        end else begin
            exp_r = exp_p + $signed({10'd0, rsum[24]});
        end

        if (a_nan) begin
            product = {sa, 8'hFF, 1'b1, fa[21:0]};
        end else if (b_nan) begin
            product = {sb, 8'hFF, 1'b1, fb[21:0]};
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            product = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            product = {sp, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            product = {sp, 31'd0};
        end else if (exp_r >= 11'sd255) begin
            product = {sp, 8'hFF, 23'd0};
        end else begin
            product = {sp, exp_r[7:0], rsum[22:0]};
        end

        prod_nan  = (product[30:23] == 8'hFF) && (product[22:0] != 23'd0);
        prod_inf  = (product[30:23] == 8'hFF) && (product[22:0] == 23'd0);
        prod_zero = (product[30:0] == 31'd0);
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        grant      = last_grant;
        found      = 1'b0;
        cnt_done   = (cnt == CNT_W'(MUL_LAT - 1));
        resp_valid = (state == RESP);
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    if (!found && req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
                        found = 1'b1;
                        grant = ID_W'((int'(last_grant) + k) % NUM_REQ);
                    end
                end
                if (found) begin
                    req_ready[grant] = 1'b1;
                    state_next       = BUSY;
                end
            end
            BUSY: begin
                if (cnt_done) state_next = RESP;
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            id         <= '0;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            resp_data  <= '0;
            resp_id    <= '0;
            resp_nan   <= 1'b0;
            resp_inf   <= 1'b0;
            resp_zero  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (found) begin
                        op_a       <= req_a[32*int'(grant) +: 32];
                        op_b       <= req_b[32*int'(grant) +: 32];
                        id         <= grant;
                        last_grant <= grant;
                        cnt        <= '0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (cnt_done) begin
                        resp_data <= product;
                        resp_id   <= id;
                        resp_nan  <= prod_nan;
                        resp_inf  <= prod_inf;
                        resp_zero <= prod_zero;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
